// File: rtl/data_mem_access_unit_if.sv
// Request/response and RAM-side signals of the MEM-stage load/store unit.
// The unit sits on the slave modport; the pipeline and the RAM macro together form the master side.
//
// Handshake: a request transfers on the rising edge where req_valid & req_ready are both 1.
// The request fields only need to be stable in that cycle. req_ready is 1 only while the unit is idle.
// resp_valid is a single-cycle pulse with no backpressure.
// resp_err and resp_rdata are meaningful only while resp_valid is 1, and are 0 otherwise.
interface data_mem_access_unit_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              ram_en;
  logic              ram_we;
  logic              ram_re;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_err, resp_rdata, ram_addr, ram_din, ram_en, ram_we, ram_re
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_err, resp_rdata, ram_addr, ram_din, ram_en, ram_we, ram_re
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Load/store front end between the MEM stage and a single-port read-first data RAM.
// Handles byte/halfword/word accesses, sub-word read-modify-write, load extension and error flagging.
module data_mem_access_unit #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_access_unit_if.slave bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // Request fields captured at acceptance
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        we_q;
  logic [15:0] wdata_q;

  // Output registers and their next values
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept = bus.req_valid & req_ready_q;

  // Upper address bits beyond the RAM span must be zero
  assign req_err = (bus.req_size == SZ_ILL)
                 || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                 || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
                 || ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);

  assign lane_byte = bus.ram_dout[{lane_q, 3'b000} +: 8];
  assign lane_half = bus.ram_dout[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = bus.ram_dout;
    case (size_q)
      SZ_BYTE: load_data = sgn_q ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
      SZ_HALF: load_data = sgn_q ? {{16{lane_half[15]}}, lane_half} : {16'd0, lane_half};
      default: load_data = bus.ram_dout;
    endcase
  end

  always_comb begin
    merged = bus.ram_dout;
    if (size_q == SZ_BYTE) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ISSUE;
            ram_en_d   = 1'b1;
            ram_addr_d = bus.req_addr[ADDR_W+1:2];
            if (bus.req_we && (bus.req_size == SZ_WORD)) begin
              ram_we_d  = 1'b1;
              ram_din_d = bus.req_wdata;
            end
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        if (we_q && (size_q == SZ_WORD)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(READ_LAT);
        end
      end
      WAIT: begin
        // Last wait cycle: ram_dout holds the word read in ISSUE
        if (cnt_q == 3'd1) begin
          if (we_q) begin
            state_d   = WRITE;
            ram_en_d  = 1'b1;
            ram_we_d  = 1'b1;
            ram_din_d = merged;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      ram_addr_q   <= '0;
      ram_din_q    <= 32'd0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 16'd0;
    end else if (accept) begin
      lane_q  <= bus.req_addr[1:0];
      size_q  <= bus.req_size;
      sgn_q   <= bus.req_signed;
      we_q    <= bus.req_we;
      wdata_q <= bus.req_wdata[15:0];
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_re     = ram_re_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: RAM model, transaction-level timeline model with a per-cycle compare,
// and directed loads/stores with literal expectations.
module tb_data_mem_access_unit;

  localparam int ADDR_W   = 10;
  localparam int READ_LAT = 2;
  localparam int TL       = 2048;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel_cyc = 0;

  data_mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_access_unit #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM: read-first, READ_LAT-cycle output pipeline ----------------
  logic [31:0] ram_mem [0:(1<<ADDR_W)-1];
  logic [31:0] ram_pipe [0:READ_LAT-1];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      ram_pipe[0] <= ram_mem[bus.ram_addr];
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    end
    for (int i = 1; i < READ_LAT; i++) if (bus.ram_re) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.ram_dout = ram_pipe[READ_LAT-1];

  // ---------------- model: per-cycle expected timeline + response queue ----------------
  typedef struct packed {
    logic              valid;
    logic              en;
    logic              we;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
  } tl_t;

  tl_t         tl [0:TL-1];
  tl_t         cmp_e;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  int          undo_wa;
  logic [31:0] undo_word;
  bit          undo_ok;
  logic [32:0] cmp_x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accepted at the end of cycle c: derive every later cycle's expected outputs.
  task automatic model_accept(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata, input int c);
    int          wa, sh, r;
    logic [31:0] word, mask, val;
    wa = int'(addr[ADDR_W+1:2]);
    sh = 8 * int'(addr[1:0]);
    undo_ok = 0;
    if (c + READ_LAT + 4 >= TL) $fatal(1, "timeline exhausted");
    if (size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)
        || addr >= (32'd1 << (ADDR_W + 2))) begin
      r = c + 1;
      exp_q.push_back({1'b1, 32'd0});
    end else begin
      word = ref_mem[wa];
      tl[c+1].en   = 1'b1;
      tl[c+1].addr = addr[ADDR_W+1:2];
      if (we && size == 2'b10) begin
        tl[c+1].we  = 1'b1;
        tl[c+1].din = wdata;
        ref_mem[wa] = wdata;
        r = c + 2;
        exp_q.push_back({1'b0, 32'd0});
      end else if (!we) begin
        if (size == 2'b10) val = word;
        else if (size == 2'b01) begin
          val = (word >> sh) & 32'h0000FFFF;
          if (sgn && val[15]) val = val | 32'hFFFF0000;
        end else begin
          val = (word >> sh) & 32'h000000FF;
          if (sgn && val[7]) val = val | 32'hFFFFFF00;
        end
        r = c + 2 + READ_LAT;
        exp_q.push_back({1'b0, val});
      end else begin
        mask = ((size == 2'b01) ? 32'h0000FFFF : 32'h000000FF) << sh;
        val  = (word & ~mask) | ((wdata << sh) & mask);
        tl[c+2+READ_LAT].en   = 1'b1;
        tl[c+2+READ_LAT].we   = 1'b1;
        tl[c+2+READ_LAT].addr = addr[ADDR_W+1:2];
        tl[c+2+READ_LAT].din  = val;
        undo_wa   = wa;
        undo_word = word;
        undo_ok   = 1;
        ref_mem[wa] = val;
        r = c + 3 + READ_LAT;
        exp_q.push_back({1'b0, 32'd0});
      end
    end
    tl[r].valid = 1'b1;
    for (int k = c + 1; k <= r; k++) tl[k].busy = 1'b1;
  endtask

  // Reset drops any transaction in flight; an unfinished read-modify-write leaves memory untouched.
  task automatic model_abort(input int c);
    for (int k = c; k < TL; k++) tl[k] = '0;
    exp_q.delete();
    if (undo_ok) ref_mem[undo_wa] = undo_word;
    undo_ok = 0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_ctrl", 32'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.ram_en, bus.ram_we, bus.ram_re}), 32'd0);
      check("rst_data", bus.resp_rdata | bus.ram_din | 32'(bus.ram_addr), 32'd0);
    end else if (cyc < TL) begin
      cmp_e = tl[cyc];
      check("req_ready", 32'(bus.req_ready), 32'((cyc > rel_cyc) && !cmp_e.busy));
      check("ram_re", 32'(bus.ram_re), 32'(cyc > rel_cyc));
      check("resp_valid", 32'(bus.resp_valid), 32'(cmp_e.valid));
      check("ram_en", 32'(bus.ram_en), 32'(cmp_e.en));
      check("ram_we", 32'(bus.ram_we), 32'(cmp_e.we));
      if (cmp_e.en) check("ram_addr", 32'(bus.ram_addr), 32'(cmp_e.addr));
      if (cmp_e.we) check("ram_din", bus.ram_din, cmp_e.din);
      if (!cmp_e.valid) begin
        check("resp_idle", bus.resp_rdata | 32'(bus.resp_err), 32'd0);
      end else if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          cmp_x = exp_q.pop_front();
          check("resp_err", 32'(bus.resp_err), 32'(cmp_x[32]));
          check("resp_rdata", bus.resp_rdata, cmp_x[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_accept(output int acc_c);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check("accept_timeout", 32'd0, 32'd1);
      acc_c = -1;
    end else begin
      acc_c = cyc;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit keep,
                        output logic [31:0] rdata, output logic err, output int acc_c, output int lat);
    int n;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    rdata = 32'hx;
    err   = 1'bx;
    lat   = -1;
    wait_accept(acc_c);
    if (acc_c < 0) begin
      bus.req_valid = 1'b0;
      return;
    end
    model_accept(we, size, sgn, addr, wdata, acc_c);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.resp_valid !== 1'b1 && n < 40);
    if (n >= 40) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    lat   = cyc - acc_c;
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] rd;
  logic        er;
  int          ac, ac2, lt;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    undo_ok        = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 32'd0;
    #1 reset = 1'b0;
    model_abort(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    rel_cyc = cyc;

    // word round trip
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, ac, lt);
    check("sw_lat", 32'(lt), 32'd2);
    check("sw_err", 32'(er), 32'd0);
    check("sw_ram_word4", ram_mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er, ac, lt);
    check("lw_lat", 32'(lt), 32'd4);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);

    // signed / unsigned sub-word loads
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12348076, 0, rd, er, ac, lt);
    do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0, rd, er, ac, lt);
    check("lb_0x21", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, rd, er, ac, lt);
    check("lbu_0x21", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, rd, er, ac, lt);
    check("lh_0x22", rd, 32'h00001234);

    // read-modify-write
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hAABBCCDD, 0, rd, er, ac, lt);
    do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h00005566, 0, rd, er, ac, lt);
    check("sh_lat", 32'(lt), 32'd5);
    check("sh_ram_word", ram_mem[12], 32'h5566CCDD);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, rd, er, ac, lt);
    check("lw_after_sh", rd, 32'h5566CCDD);
    do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 0, rd, er, ac, lt);
    check("lh_0x30", rd, 32'hFFFFCCDD);
    do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 0, rd, er, ac, lt);
    check("lhu_0x32", rd, 32'h00005566);
    do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 0, rd, er, ac, lt);
    check("lbu_0x33", rd, 32'h00000055);
    do_req(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000009A, 0, rd, er, ac, lt);
    do_req(1'b1, 2'b00, 1'b0, 32'h30, 32'h12345680, 0, rd, er, ac, lt);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, rd, er, ac, lt);
    check("lw_after_sb", rd, 32'h55669A80);

    // highest legal word
    do_req(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, 0, rd, er, ac, lt);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 0, rd, er, ac, lt);
    check("lw_top", rd, 32'hCAFEF00D);

    // errors
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, rd, er, ac, lt);
    check("err_lw_mis", {rd[30:0], er}, 32'd1);
    check("err_lw_mis_lat", 32'(lt), 32'd1);
    do_req(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 0, rd, er, ac, lt);
    check("err_lh_mis", {rd[30:0], er}, 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, rd, er, ac, lt);
    check("err_size", {rd[30:0], er}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, rd, er, ac, lt);
    check("err_range", {rd[30:0], er}, 32'd1);
    do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h55555555, 0, rd, er, ac, lt);
    check("err_sw_range", {rd[30:0], er}, 32'd1);
    check("err_sw_lat", 32'(lt), 32'd1);
    check("err_sw_no_write", ram_mem[0], ref_mem[0]);

    // busy ignore: request held high through a load, next one waits for IDLE
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, rd, er, ac, lt);
    check("busy_first", rd, 32'h12348076);
    do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, rd, er, ac2, lt);
    check("busy_second_accept", 32'(ac2 - ac), 32'd5);
    check("busy_second_data", rd, 32'h00000080);

    // reset in WAIT of an sb
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 0, rd, er, ac, lt);
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h41;
    bus.req_wdata  = 32'h000000FF;
    bus.req_valid  = 1'b1;
    wait_accept(ac);
    if (ac >= 0) model_accept(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000FF, ac);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    model_abort(cyc);
    #1;
    check("rst_async_outputs", 32'({bus.req_ready, bus.resp_valid, bus.ram_en, bus.ram_we, bus.ram_re}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    rel_cyc = cyc;
    check("rst_no_write", ram_mem[16], 32'h11223344);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, rd, er, ac, lt);
    check("lw_after_rst", rd, 32'h11223344);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Load/store front end between the MIPS MEM pipeline stage and the 32-bit single-port data RAM (read-first; two-cycle read latency in HIGH_PERFORMANCE mode).
- Accepts byte, halfword and word loads and stores at byte addresses.
- Performs read-modify-write for sub-word stores, and sign or zero extension for loads.
- Flags misaligned and out-of-range accesses without touching the RAM.

Parameters:
ADDR_W, 10, RAM word-address width (RAM depth = 2**ADDR_W words)
READ_LAT, 2, RAM read latency in cycles from ram_en sample to valid ram_dout (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY); legal values 1..4

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle; request accepted when req_valid & req_ready
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  load sign-extends when 1
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid; misaligned, illegal size or out of range
resp_rdata  output  32  load result; 0 for stores and errors
ram_addr  output  ADDR_W  RAM word address
ram_din  output  32  RAM write data
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_re  output  1  RAM output-register enable, constant 1 out of reset

Behaviour:
- Registered outputs.
  - All outputs are driven from registers.
  - Reset (reset=0) asynchronously clears every output to 0, sets state to IDLE and drops any pending request.
  - ram_re is 1 from the first clock edge after reset deasserts.
- States: IDLE, ISSUE, WAIT, WRITE, RESP.
- req_ready = 1 only in IDLE. Requests while busy are ignored: no side effects, no queuing.
- Request acceptance.
  - The request is accepted in cycle 0, i.e. sampled at the end of cycle 0.
  - Address, size, signed flag, we and wdata are latched at that edge.
  - Word address = req_addr[ADDR_W+1:2]. Byte lane = req_addr[1:0]. Lanes are little-endian: lane k = bits 8k+7:8k.
- Error check at acceptance.
  - An access is an error if any of these holds: size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:ADDR_W+2]!=0.
  - Error path: no RAM activity; go to RESP. Cycle 1: resp_valid=1, resp_err=1, resp_rdata=0.
- Word store: ISSUE in cycle 1 with ram_en=1, ram_we=1, ram_din=wdata. RESP in cycle 2 with resp_valid=1.
- Load:
  - Cycle 1: ISSUE with ram_en=1, ram_we=0.
  - Cycles 2..1+READ_LAT: WAIT, using a down-counter loaded with READ_LAT.
  - End of cycle 1+READ_LAT: ram_dout is sampled, the lane is extracted and extended.
  - Cycle 2+READ_LAT: RESP with resp_valid=1 and resp_rdata set.
  - Byte result: lane byte, with bit 7 replicated if signed, else zero-filled. Halfword result: lane pair (addr[1] selects the upper half), with bit 15 replicated if signed. Word result: ram_dout as-is.
- Sub-word store (read-modify-write):
  - Read phase is identical to a load through cycle 1+READ_LAT.
  - At the end of that cycle, the merged word is formed: ram_dout with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Cycle 2+READ_LAT: WRITE with ram_en=1, ram_we=1, ram_din=merged.
  - Cycle 3+READ_LAT: RESP.
- ram_en and ram_we are 0 in every state except ISSUE and WRITE. ram_we is 1 in ISSUE only for a word store.
- RESP lasts exactly one cycle, then IDLE. req_ready rises in the cycle after RESP. No response backpressure.
- Reset during WRITE: ram_we falls asynchronously and the partial update is abandoned. RAM contents are as left by any completed edge.
- resp_rdata and resp_err return to 0 outside RESP.

Test Plan:
- Word round trip: sw 0xDEADBEEF to 0x00000010 -> ram_we=1 with ram_addr=4 in cycle 1, resp_valid cycle 2. Then lw 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid in cycle 4 (READ_LAT=2).
- Signed/unsigned byte: word 0x12348076 at 0x20; lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080; lh 0x22 -> 0x00001234.
- RMW halfword: word 0xAABBCCDD at 0x30; sh 0x5566 to 0x32 -> single write cycle 4 with ram_din=0x5566CCDD, resp_valid cycle 5. A following lw 0x30 returns 0x5566CCDD.
- Errors: lw 0x102, lh 0x101, size=11, lw 0x00001000 (ADDR_W=10) -> resp_err=1, resp_rdata=0 in cycle 1, ram_en never asserted.
- Busy ignore: second req_valid held during a load -> req_ready=0, no extra ram_en pulse, second request accepted only after return to IDLE.
- Reset mid-RMW: assert reset in WAIT of sb 0xFF to 0x41 -> all outputs 0 immediately, no RAM write, original word unchanged on later lw.
